// File: rtl/fetch_bid_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_bid_ctrl_pkg : branch-ID constants, types and helpers          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package fetch_bid_ctrl_pkg;

  localparam int DEPTH = 8;
  localparam int IDX_W = 3;
  localparam int BID_W = IDX_W + 1;

  typedef logic [BID_W-1:0] bid_t;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [IDX_W:0]   cnt_t;

  // Modulo 2^BID_W increment; the wrap bit toggles when the index rolls over.
  function automatic bid_t bid_inc(input bid_t b);
    return b + {{(BID_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic idx_t bid_idx(input bid_t b);
    return b[IDX_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_bid_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_bid_ctrl_if : allocate / commit / override / status bundle     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface fetch_bid_ctrl_if;
  import fetch_bid_ctrl_pkg::*;

  logic alloc_valid;
  logic alloc_ready;
  bid_t alloc_bid;
  logic bc_valid;
  bid_t bc_bid;
  logic bco_valid;
  bid_t bco_bid;
  logic flush_valid;
  bid_t flush_bid;
  bid_t head_bid;
  cnt_t inflight;
  logic empty;
  logic full;
  logic err_order;

  modport slave (
    input  alloc_valid, bc_valid, bc_bid, bco_valid, bco_bid,
    output alloc_ready, alloc_bid, flush_valid, flush_bid,
           head_bid, inflight, empty, full, err_order
  );

  modport master (
    output alloc_valid, bc_valid, bc_bid, bco_valid, bco_bid,
    input  alloc_ready, alloc_bid, flush_valid, flush_bid,
           head_bid, inflight, empty, full, err_order
  );

endinterface
`default_nettype wire

// File: rtl/fetch_bid_ptr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_bid_ptr : wrap-bit pointer register with increment and load    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fetch_bid_ptr
  import fetch_bid_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic inc_i,
  input  logic load_i,
  input  bid_t load_val_i,
  output bid_t ptr_o
);

  bid_t ptr_q;
  bid_t ptr_d;

  // Load wins over increment so an override cleanly repositions the pointer.
  always_comb begin
    ptr_d = ptr_q;
    if (load_i) begin
      ptr_d = load_val_i;
    end else if (inc_i) begin
      ptr_d = bid_inc(ptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule
`default_nettype wire

// File: rtl/fetch_bid_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_bid_ctrl : branch-ID allocator and in-order in-flight tracker  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fetch_bid_ctrl
  import fetch_bid_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  fetch_bid_ctrl_if.slave  bus
);

  bid_t head_q;
  bid_t tail_q;
  cnt_t cnt_q;
  cnt_t cnt_d;
  logic err_q;
  logic err_d;
  logic flush_q;
  bid_t flush_bid_q;

  logic full_w;
  logic empty_w;
  logic alloc_fire;
  logic commit_req;
  logic commit_ok;
  logic commit_bad;
  bid_t bco_next;

  assign full_w  = (bid_idx(head_q) == bid_idx(tail_q)) &
                   (head_q[IDX_W] != tail_q[IDX_W]);
  assign empty_w = (head_q == tail_q);

  // Override squashes any same-cycle allocate or commit.
  assign alloc_fire = bus.alloc_valid & ~full_w & ~bus.bco_valid;
  assign commit_req = bus.bc_valid & ~bus.bco_valid;
  assign commit_ok  = commit_req & ~empty_w & (bus.bc_bid == head_q);
  assign commit_bad = commit_req & ~commit_ok;
  assign bco_next   = bid_inc(bus.bco_bid);

  fetch_bid_ptr u_head_ptr (
    .clk        (clk),
    .reset      (reset),
    .inc_i      (commit_ok),
    .load_i     (bus.bco_valid),
    .load_val_i (bco_next),
    .ptr_o      (head_q)
  );

  fetch_bid_ptr u_tail_ptr (
    .clk        (clk),
    .reset      (reset),
    .inc_i      (alloc_fire),
    .load_i     (bus.bco_valid),
    .load_val_i (bco_next),
    .ptr_o      (tail_q)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (bus.bco_valid) begin
      cnt_d = '0;
    end else if (alloc_fire & ~commit_ok) begin
      cnt_d = cnt_q + {{IDX_W{1'b0}}, 1'b1};
    end else if (commit_ok & ~alloc_fire) begin
      cnt_d = cnt_q - {{IDX_W{1'b0}}, 1'b1};
    end
  end

  assign err_d = err_q | commit_bad;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      err_q       <= 1'b0;
      flush_q     <= 1'b0;
      flush_bid_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      flush_q <= bus.bco_valid;
      if (bus.bco_valid) begin
        flush_bid_q <= bco_next;
      end
    end
  end

  assign bus.alloc_ready = ~full_w;
  assign bus.alloc_bid   = tail_q;
  assign bus.flush_valid = flush_q;
  assign bus.flush_bid   = flush_bid_q;
  assign bus.head_bid    = head_q;
  assign bus.inflight    = cnt_q;
  assign bus.empty       = empty_w;
  assign bus.full        = full_w;
  assign bus.err_order   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_bid_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_bid_ctrl : directed scoreboard bench for fetch_bid_ctrl     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_fetch_bid_ctrl;

  logic clk;
  logic reset;

  fetch_bid_ctrl_if bus();

  fetch_bid_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] head;
    logic [3:0] tail;
    logic [3:0] cnt;
    logic       err;
    logic       fv;
    logic [3:0] fb;
    logic       chk_fb;
    int         id;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_step  = 0;

  task automatic chk(input string name, input int id,
                     input logic [7:0] got, input logic [7:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h, expected %0h", name, id, got, want);
    end
  endtask

  // Drive one cycle of inputs, then queue the state expected after that edge.
  task automatic step(input logic rst, input logic av, input logic bcv,
                      input logic [3:0] bcb, input logic bcov, input logic [3:0] bcob,
                      input logic [3:0] eh, input logic [3:0] et, input logic [3:0] ec,
                      input logic ee, input logic efv, input logic [3:0] efb);
    exp_t e;
    reset           = rst;
    bus.alloc_valid = av;
    bus.bc_valid    = bcv;
    bus.bc_bid      = bcb;
    bus.bco_valid   = bcov;
    bus.bco_bid     = bcob;
    @(posedge clk);
    #1;
    e.head = eh; e.tail = et; e.cnt = ec; e.err = ee;
    e.fv = efv; e.fb = efb; e.chk_fb = efv | rst; e.id = n_step;
    exp_q.push_back(e);
    n_step++;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("alloc_ready", e.id, {7'd0, bus.alloc_ready}, {7'd0, (e.cnt != 4'd8)});
      chk("alloc_bid",   e.id, {4'd0, bus.alloc_bid},   {4'd0, e.tail});
      chk("head_bid",    e.id, {4'd0, bus.head_bid},    {4'd0, e.head});
      chk("inflight",    e.id, {4'd0, bus.inflight},    {4'd0, e.cnt});
      chk("empty",       e.id, {7'd0, bus.empty},       {7'd0, (e.head == e.tail)});
      chk("full",        e.id, {7'd0, bus.full},        {7'd0, (e.cnt == 4'd8)});
      chk("err_order",   e.id, {7'd0, bus.err_order},   {7'd0, e.err});
      chk("flush_valid", e.id, {7'd0, bus.flush_valid}, {7'd0, e.fv});
      if (e.chk_fb) begin
        chk("flush_bid", e.id, {4'd0, bus.flush_bid}, {4'd0, e.fb});
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.alloc_valid = 1'b0; bus.bc_valid = 1'b0; bus.bc_bid = '0;
    bus.bco_valid = 1'b0; bus.bco_bid = '0;

    // Reset, then fill the window with IDs 0..7.
    step(1,0,0,4'h0,0,4'h0, 4'h0,4'h0,4'd0,0,0,4'h0);
    for (int i = 1; i <= 8; i++)
      step(0,1,0,4'h0,0,4'h0, 4'h0,4'(i),4'(i),0,0,4'h0);
    step(0,1,0,4'h0,0,4'h0, 4'h0,4'h8,4'd8,0,0,4'h0);
    step(0,1,1,4'h0,0,4'h0, 4'h1,4'h8,4'd7,0,0,4'h0);
    step(0,1,0,4'h0,0,4'h0, 4'h1,4'h9,4'd8,0,0,4'h0);

    // Allocate 0..4, retire 0..2, override on 2.
    step(1,0,0,4'h0,0,4'h0, 4'h0,4'h0,4'd0,0,0,4'h0);
    for (int i = 1; i <= 5; i++)
      step(0,1,0,4'h0,0,4'h0, 4'h0,4'(i),4'(i),0,0,4'h0);
    step(0,0,1,4'h0,0,4'h0, 4'h1,4'h5,4'd4,0,0,4'h0);
    step(0,0,1,4'h1,0,4'h0, 4'h2,4'h5,4'd3,0,0,4'h0);
    step(0,0,1,4'h2,0,4'h0, 4'h3,4'h5,4'd2,0,0,4'h0);
    step(0,0,0,4'h0,1,4'h2, 4'h3,4'h3,4'd0,0,1,4'h3);
    step(0,0,0,4'h0,0,4'h0, 4'h3,4'h3,4'd0,0,0,4'h3);
    step(0,1,0,4'h0,0,4'h0, 4'h3,4'h4,4'd1,0,0,4'h3);

    // Alloc, commit and override together: override alone takes effect.
    step(0,1,1,4'h3,1,4'h5, 4'h6,4'h6,4'd0,0,1,4'h6);
    step(0,0,0,4'h0,0,4'h0, 4'h6,4'h6,4'd0,0,0,4'h6);

    // Commit while empty sets the sticky error.
    step(0,0,1,4'h6,0,4'h0, 4'h6,4'h6,4'd0,1,0,4'h6);
    step(0,0,0,4'h0,0,4'h0, 4'h6,4'h6,4'd0,1,0,4'h6);

    // Out-of-order commit, then normal traffic with the error held.
    step(1,0,0,4'h0,0,4'h0, 4'h0,4'h0,4'd0,0,0,4'h0);
    step(0,1,0,4'h0,0,4'h0, 4'h0,4'h1,4'd1,0,0,4'h0);
    step(0,1,0,4'h0,0,4'h0, 4'h0,4'h2,4'd2,0,0,4'h0);
    step(0,0,1,4'h0,0,4'h0, 4'h1,4'h2,4'd1,0,0,4'h0);
    step(0,1,0,4'h0,0,4'h0, 4'h1,4'h3,4'd2,0,0,4'h0);
    step(0,0,1,4'h3,0,4'h0, 4'h1,4'h3,4'd2,1,0,4'h0);
    step(0,1,1,4'h1,0,4'h0, 4'h2,4'h4,4'd2,1,0,4'h0);
    step(0,1,0,4'h0,0,4'h0, 4'h2,4'h5,4'd3,1,0,4'h0);
    step(0,1,0,4'h0,0,4'h0, 4'h2,4'h6,4'd4,1,0,4'h0);
    step(0,1,0,4'h0,0,4'h0, 4'h2,4'h7,4'd5,1,0,4'h0);

    // Reset with five in flight; then an override on ID 15 wraps to 0.
    step(1,0,0,4'h0,0,4'h0, 4'h0,4'h0,4'd0,0,0,4'h0);
    step(0,1,0,4'h0,0,4'h0, 4'h0,4'h1,4'd1,0,0,4'h0);
    step(0,0,0,4'h0,1,4'hf, 4'h0,4'h0,4'd0,0,1,4'h0);
    step(0,0,0,4'h0,0,4'h0, 4'h0,4'h0,4'd0,0,0,4'h0);

    for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_bid_ctrl.md
Name: fetch_bid_ctrl

Overview:
Branch-ID allocator and in-flight tracker for the fetch stage. Issues 4-bit branch IDs (wrap bit + 3-bit table index) to predicted branches and tracks them as an 8-deep circular window. Retires IDs in order on backend branch commit. Reclaims all younger IDs when the branch recovery table signals a commit override (misprediction).

Parameters:
DEPTH, 8, number of in-flight branch IDs; power of two, equal to recovery-table entry count
IDX_W, 3, log2(DEPTH); table index width
BID_W, 4, IDX_W+1; branch ID width, MSB is the wrap bit

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
alloc_valid  in  1  fetch requests a branch ID for a predicted branch
alloc_ready  out  1  ID available (not full)
alloc_bid  out  BID_W  ID granted; valid when alloc_valid & alloc_ready
bc_valid  in  1  backend branch commit
bc_bid  in  BID_W  ID of committing branch
bco_valid  in  1  recovery-table override (mispredict) pulse
bco_bid  in  BID_W  ID of the overriding branch
flush_valid  out  1  registered pulse: wrong-path IDs squashed
flush_bid  out  BID_W  first squashed ID (new allocation point)
head_bid  out  BID_W  oldest in-flight ID
inflight  out  IDX_W+1  in-flight count, 0..DEPTH
empty  out  1  inflight == 0
full  out  1  inflight == DEPTH
err_order  out  1  sticky: commit ID != head_bid, or commit while empty

Behaviour:
- State: head_q, tail_q (BID_W each), cnt_q (IDX_W+1), err_q, flush_q, flush_bid_q.
- Reset (reset=1 at posedge): head_q=tail_q=0, cnt_q=0, err_q=0, flush_valid=0, flush_bid=0. Therefore alloc_ready=1, alloc_bid=0, head_bid=0, empty=1, full=0, err_order=0. A reset mid-operation discards all in-flight IDs; the next alloc_bid is 0.
- full = (head_q[IDX_W-1:0]==tail_q[IDX_W-1:0]) & (head_q[IDX_W]!=tail_q[IDX_W]). empty = (head_q==tail_q). cnt_q must agree with these; the bench checks all three.
- alloc_ready = ~full; combinational from registered state only. No same-cycle bypass from commit. alloc_bid = tail_q (combinational).
- Allocate: alloc_valid & alloc_ready & ~bco_valid -> tail_q += 1 (modulo 2^BID_W, wrap bit toggles at index 7->0). Zero-latency grant. The ID is usable as bp_bid in the same cycle.
- Commit: bc_valid & ~bco_valid.
  - If ~empty & bc_bid==head_q: head_q += 1.
  - Otherwise: err_q <= 1, and head_q is unchanged.
- Simultaneous allocate + commit: both apply, and cnt_q is unchanged.
- Override (bco_valid=1) has priority over everything in its cycle:
  - tail_q <= bco_bid+1 and head_q <= bco_bid+1 (window empty, since the overriding branch has already retired).
  - cnt_q <= 0.
  - alloc and bc in the same cycle are ignored. alloc_ready stays as computed, so fetch must treat the grant as void when bco_valid is high.
  - flush_q <= 1 and flush_bid_q <= bco_bid+1 for exactly one cycle (1-cycle latency).
- bco_bid is not range-checked. The block trusts the recovery table.
- err_order is cleared only by reset.
- Width rule: all ID arithmetic is unsigned, modulo 2^BID_W. Carry out of the MSB is dropped.

Decomposition:
- Shared fetch package holds:
  - BID_W, IDX_W, DEPTH constants
  - the bid_t typedef
  - a bid_inc function (modulo increment)
  - a bid_idx function (drops the wrap bit)
  - the recovery table reuses the same constants
- One natural sub-module: fetch_bid_ptr, a BID_W-bit wrap pointer register with increment/load/reset. Instantiated twice, for head and tail.
- Full/empty logic and flush register stay in the top module.

Test Plan:
- Reset, then 8 back-to-back allocs -> alloc_bid 0..7; after the 8th, full=1, alloc_ready=0, inflight=8. A 9th alloc_valid does not move the tail.
- From full, commit bc_bid=0 together with alloc_valid -> alloc not granted that cycle (ready=0). Next cycle alloc_ready=1, alloc_bid=8 (wrap bit set, index 0), head_bid=1.
- Alloc 0..4, commit 0,1,2, then bco_valid with bco_bid=2 -> next cycle flush_valid=1 for one cycle, flush_bid=3, empty=1, head_bid=3, next alloc_bid=3.
- Same-cycle alloc_valid, bc_valid, bco_valid (bco_bid=5) -> alloc and commit ignored; head_bid=tail=6, inflight=0.
- Commit bc_bid=3 while head_bid=1, or commit while empty -> err_order=1 and stays 1. head_bid is unchanged. Only reset clears it.
- Reset asserted with 5 IDs in flight -> next cycle inflight=0, alloc_bid=0, flush_valid=0, err_order=0.
